// File: rtl/guess_button_encoder_pkg.sv
// Shared constants and FSM encoding for the button-to-guess front end.
// The game core imports the position-count constants from here as well.
package guess_button_encoder_pkg;

    localparam int unsigned N_BTN_DEFAULT           = 8;
    localparam int unsigned GUESS_W_DEFAULT         = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeld    = 2'd1,
        StRelease = 2'd2
    } state_e;

endpackage

// File: rtl/btn_debouncer.sv
// Single-button 2-FF synchroniser followed by a stable-count filter.
// btn_db only changes after the synchronised level differs for DEBOUNCE_CYCLES cycles in a row.
module btn_debouncer
    import guess_button_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            // A glitch back to the accepted level restarts the filter.
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign btn_db = stable_q;

endmodule

// File: rtl/guess_button_encoder.sv
// Turns raw mole buttons into a registered user_guess index with one-cycle eval_now /
// multi_press strobes; one strobe per press episode, re-armed only after a full release.
module guess_button_encoder
    import guess_button_encoder_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter int unsigned GUESS_W         = GUESS_W_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   btn,
    input  logic               guess_enable,
    output logic [GUESS_W-1:0] user_guess,
    output logic               eval_now,
    output logic               multi_press,
    output logic [N_BTN-1:0]   btn_db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn_debouncer (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn[i]),
            .btn_db (btn_db[i])
        );
    end

    function automatic int unsigned popcount(input logic [N_BTN-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N_BTN; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

    // Only ever applied to a one-hot vector, so the last match is the only match.
    function automatic logic [GUESS_W-1:0] encode(input logic [N_BTN-1:0] v);
        logic [GUESS_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (v[i]) begin
                idx = GUESS_W'(i);
            end
        end
        return idx;
    endfunction

    state_e             state_q, state_d;
    logic [GUESS_W-1:0] guess_q, guess_d;
    logic               eval_q, eval_d;
    logic               multi_q, multi_d;
    int unsigned        n_down;

    assign n_down = popcount(btn_db);

    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        eval_d  = 1'b0;
        multi_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (n_down > 1) begin
                    multi_d = 1'b1;
                    state_d = StHeld;
                end else if (n_down == 1) begin
                    // A press with guess_enable low is consumed so it cannot fire later.
                    if (guess_enable) begin
                        guess_d = encode(btn_db);
                        eval_d  = 1'b1;
                    end
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (btn_db == '0) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            guess_q <= '0;
            eval_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            guess_q <= guess_d;
            eval_q  <= eval_d;
            multi_q <= multi_d;
        end
    end

    assign user_guess  = guess_q;
    assign eval_now    = eval_q;
    assign multi_press = multi_q;

endmodule
